// File: rtl/pll_lock_seq_if.sv
// Signal bundle between the PLL lock sequencer and the PLL / system side.
// The sequencer is the slave: it takes restart and raw lock, and drives the PLL controls and status.
interface pll_lock_seq_if;
    logic       restart_i;
    logic       pll_lock_i;
    logic       pll_reset_o;
    logic [5:0] icpsel_o;
    logic [2:0] lpfres_o;
    logic [1:0] lpfcap_o;
    logic       ready_o;
    logic       fail_o;
    logic [3:0] try_o;
    logic [7:0] relock_cnt_o;

    modport master (
        output restart_i, pll_lock_i,
        input  pll_reset_o, icpsel_o, lpfres_o, lpfcap_o,
        input  ready_o, fail_o, try_o, relock_cnt_o
    );

    modport slave (
        input  restart_i, pll_lock_i,
        output pll_reset_o, icpsel_o, lpfres_o, lpfcap_o,
        output ready_o, fail_o, try_o, relock_cnt_o
    );
endinterface

// File: rtl/pll_lock_seq.sv
// PLL bring-up and lock supervision: holds the PLL in reset, waits for a stable lock,
// steps loop-filter settings on timeout, gives up after MAX_TRIES and re-locks after lock loss.
module pll_lock_seq #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_TRIES     = 8,
    parameter int ICP_INIT      = 16,
    parameter int ICP_STEP      = 4,
    parameter int LPFRES_INIT   = 2,
    parameter int LPFCAP_VAL    = 0,
    parameter int CNT_W         = 17
) (
    input  logic            clk,
    input  logic            rst_n,
    pll_lock_seq_if.slave   bus
);

    localparam logic [2:0] ST_PRST = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_STAB = 3'd2;
    localparam logic [2:0] ST_RUN  = 3'd3;
    localparam logic [2:0] ST_FAIL = 3'd4;

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       TRY_LAST  = 4'(MAX_TRIES - 1);
    localparam logic [5:0]       ICP_RST   = 6'(ICP_INIT);
    localparam logic [6:0]       ICP_INC   = 7'(ICP_STEP);
    localparam logic [2:0]       LPF_RST   = 3'(LPFRES_INIT);
    localparam logic [1:0]       CAP_RST   = 2'(LPFCAP_VAL);

    logic [1:0]       sync_r;
    logic             lock_s;
    logic [2:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             pll_reset_r, pll_reset_s;
    logic [5:0]       icpsel_r, icpsel_s;
    logic [2:0]       lpfres_r, lpfres_s;
    logic [1:0]       lpfcap_r;
    logic             ready_r, ready_s;
    logic             fail_r, fail_s;
    logic [3:0]       try_r, try_s;
    logic [7:0]       relock_r, relock_s;
    logic [6:0]       icp_sum_s;
    logic [5:0]       icp_step_s;

    assign lock_s = sync_r[1];

    // Two-flop synchroniser for the raw PLL lock, which is asynchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], bus.pll_lock_i};
        end
    end

    // Charge-pump current for the next attempt, saturating at the 6-bit maximum.
    always_comb begin
        icp_sum_s = {1'b0, icpsel_r} + ICP_INC;
        if (icp_sum_s > 7'd63) begin
            icp_step_s = 6'd63;
        end else begin
            icp_step_s = icp_sum_s[5:0];
        end
    end

    // Next-state and next-output logic; restart overrides every other transition.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        pll_reset_s = pll_reset_r;
        icpsel_s    = icpsel_r;
        lpfres_s    = lpfres_r;
        ready_s     = ready_r;
        fail_s      = fail_r;
        try_s       = try_r;
        relock_s    = relock_r;
        if (bus.restart_i) begin
            state_s     = ST_PRST;
            cnt_s       = '0;
            pll_reset_s = 1'b1;
            icpsel_s    = ICP_RST;
            lpfres_s    = LPF_RST;
            ready_s     = 1'b0;
            fail_s      = 1'b0;
            try_s       = 4'd0;
        end else begin
            case (state_r)
                ST_PRST: begin
                    pll_reset_s = 1'b1;
                    if (cnt_r == RST_LAST) begin
                        state_s     = ST_WAIT;
                        pll_reset_s = 1'b0;
                        cnt_s       = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (lock_s) begin
                        state_s = ST_STAB;
                        cnt_s   = '0;
                    end else if (cnt_r == TO_LAST) begin
                        cnt_s       = '0;
                        pll_reset_s = 1'b1;
                        if (try_r == TRY_LAST) begin
                            state_s = ST_FAIL;
                            fail_s  = 1'b1;
                        end else begin
                            // Settings only move on entry to PRST so they are stable under PLL reset.
                            state_s  = ST_PRST;
                            try_s    = try_r + 4'd1;
                            icpsel_s = icp_step_s;
                            lpfres_s = lpfres_r + 3'd1;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_STAB: begin
                    if (!lock_s) begin
                        state_s = ST_WAIT;
                        cnt_s   = '0;
                    end else if (cnt_r == STAB_LAST) begin
                        state_s = ST_RUN;
                        ready_s = 1'b1;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_s     = ST_PRST;
                        cnt_s       = '0;
                        pll_reset_s = 1'b1;
                        ready_s     = 1'b0;
                        if (relock_r == 8'hFF) begin
                            relock_s = 8'hFF;
                        end else begin
                            relock_s = relock_r + 8'd1;
                        end
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                ST_FAIL: begin
                    fail_s      = 1'b1;
                    pll_reset_s = 1'b1;
                end
                default: begin
                    state_s     = ST_PRST;
                    cnt_s       = '0;
                    pll_reset_s = 1'b1;
                    ready_s     = 1'b0;
                    fail_s      = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state and registered PLL control / status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_PRST;
            cnt_r       <= '0;
            pll_reset_r <= 1'b1;
            icpsel_r    <= ICP_RST;
            lpfres_r    <= LPF_RST;
            lpfcap_r    <= CAP_RST;
            ready_r     <= 1'b0;
            fail_r      <= 1'b0;
            try_r       <= 4'd0;
            relock_r    <= 8'd0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            pll_reset_r <= pll_reset_s;
            icpsel_r    <= icpsel_s;
            lpfres_r    <= lpfres_s;
            lpfcap_r    <= CAP_RST;
            ready_r     <= ready_s;
            fail_r      <= fail_s;
            try_r       <= try_s;
            relock_r    <= relock_s;
        end
    end

    assign bus.pll_reset_o  = pll_reset_r;
    assign bus.icpsel_o     = icpsel_r;
    assign bus.lpfres_o     = lpfres_r;
    assign bus.lpfcap_o     = lpfcap_r;
    assign bus.ready_o      = ready_r;
    assign bus.fail_o       = fail_r;
    assign bus.try_o        = try_r;
    assign bus.relock_cnt_o = relock_r;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq: a vector table for lock/relock/glitch/reset scenarios,
// plus hand-written sequences for the timeout chain and restart-vs-timeout priority.
module tb_pll_lock_seq;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pll_lock_seq_if bus();

    pll_lock_seq #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .MAX_TRIES    (3),
        .ICP_INIT     (60),
        .ICP_STEP     (4),
        .LPFRES_INIT  (2),
        .LPFCAP_VAL   (0),
        .CNT_W        (17)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       restart;
        logic       lock;
        int         cycles;
        logic       rst_o;
        logic [5:0] icp;
        logic [2:0] lpf;
        logic       rdy;
        logic       fl;
        logic [3:0] tr;
        logic [7:0] rl;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rs, input logic lk, input int n,
                                input logic po, input logic [5:0] ic, input logic [2:0] lp,
                                input logic rd, input logic fl, input logic [3:0] tr,
                                input logic [7:0] rl);
        vec_t v;
        v.rst_n = r;  v.restart = rs; v.lock = lk; v.cycles = n;
        v.rst_o = po; v.icp = ic; v.lpf = lp; v.rdy = rd; v.fl = fl; v.tr = tr; v.rl = rl;
        return v;
    endfunction

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d]: got %0d want %0d", nm, idx, act, exp);
        end
    endtask

    task automatic chk_all(input int idx, input logic po, input logic [5:0] ic, input logic [2:0] lp,
                           input logic rd, input logic fl, input logic [3:0] tr, input logic [7:0] rl);
        chk("pll_reset", idx, 16'(bus.pll_reset_o), 16'(po));
        chk("icpsel",    idx, 16'(bus.icpsel_o),    16'(ic));
        chk("lpfres",    idx, 16'(bus.lpfres_o),    16'(lp));
        chk("lpfcap",    idx, 16'(bus.lpfcap_o),    16'd0);
        chk("ready",     idx, 16'(bus.ready_o),     16'(rd));
        chk("fail",      idx, 16'(bus.fail_o),      16'(fl));
        chk("try",       idx, 16'(bus.try_o),       16'(tr));
        chk("relock",    idx, 16'(bus.relock_cnt_o), 16'(rl));
    endtask

    initial begin
        logic [5:0] e_icp;
        logic [2:0] e_lpf;
        logic [3:0] e_try;
        logic       e_rst;
        logic       e_fail;
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.restart_i  = 1'b0;
        bus.pll_lock_i = 1'b0;

        // rst_n restart lock cyc | pll_reset icp lpf ready fail try relock
        vecs.push_back(mk(1'b0, 1'b0, 1'b0,  2, 1'b1, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0)); // reset values
        vecs.push_back(mk(1'b1, 1'b0, 1'b0,  3, 1'b1, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0)); // PRST held
        vecs.push_back(mk(1'b1, 1'b0, 1'b0,  1, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0)); // 4th edge releases
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 10, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 10, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0)); // lock rises
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  1, 1'b0, 6'd60, 3'd2, 1'b1, 1'b0, 4'd0, 8'd0)); // ready 2+8 later
        vecs.push_back(mk(1'b1, 1'b0, 1'b0,  2, 1'b0, 6'd60, 3'd2, 1'b1, 1'b0, 4'd0, 8'd0)); // lock drop
        vecs.push_back(mk(1'b1, 1'b0, 1'b0,  1, 1'b1, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1)); // 3 cycles later
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  3, 1'b1, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1)); // relock attempt
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  1, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  8, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  1, 1'b0, 6'd60, 3'd2, 1'b1, 1'b0, 4'd0, 8'd1)); // ready again
        vecs.push_back(mk(1'b0, 1'b0, 1'b0,  0, 1'b1, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0)); // async reset in RUN
        vecs.push_back(mk(1'b1, 1'b0, 1'b0,  4, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  5, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0)); // glitch: high 5
        vecs.push_back(mk(1'b1, 1'b0, 1'b0,  1, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0)); // low 1
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 10, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0)); // high again
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  1, 1'b0, 6'd60, 3'd2, 1'b1, 1'b0, 4'd0, 8'd0)); // 2+8 after 2nd rise
        vecs.push_back(mk(1'b1, 1'b0, 1'b0,  3, 1'b1, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  4, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  3, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1)); // mid-STAB
        vecs.push_back(mk(1'b0, 1'b0, 1'b1,  0, 1'b1, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0)); // async reset
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  4, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  8, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1,  1, 1'b0, 6'd60, 3'd2, 1'b1, 1'b0, 4'd0, 8'd0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0,  3, 1'b1, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1)); // into PRST

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n          = vecs[i].rst_n;
            bus.restart_i  = vecs[i].restart;
            bus.pll_lock_i = vecs[i].lock;
            if (vecs[i].cycles > 0) tick(vecs[i].cycles);
            else #1;
            chk_all(i, vecs[i].rst_o, vecs[i].icp, vecs[i].lpf, vecs[i].rdy,
                    vecs[i].fl, vecs[i].tr, vecs[i].rl);
        end

        // Restart coinciding with the final WAIT timeout: restart must win, relock count kept.
        tick(107);
        chk_all(100, 1'b0, 6'd63, 3'd4, 1'b0, 1'b0, 4'd2, 8'd1);
        bus.restart_i = 1'b1;
        tick(1);
        bus.restart_i = 1'b0;
        chk_all(101, 1'b1, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1);
        tick(107);
        chk_all(102, 1'b0, 6'd63, 3'd4, 1'b0, 1'b0, 4'd2, 8'd1);
        tick(1);
        chk_all(103, 1'b1, 6'd63, 3'd4, 1'b0, 1'b1, 4'd2, 8'd1);
        tick(5);
        chk_all(104, 1'b1, 6'd63, 3'd4, 1'b0, 1'b1, 4'd2, 8'd1);
        bus.restart_i = 1'b1;
        tick(1);
        bus.restart_i = 1'b0;
        chk_all(105, 1'b1, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1);
        tick(3);
        chk_all(106, 1'b1, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1);
        tick(1);
        chk_all(107, 1'b0, 6'd60, 3'd2, 1'b0, 1'b0, 4'd0, 8'd1);

        // Never lock from reset: each attempt is 4 reset + 32 wait cycles, fail at edge 108.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int k = 1; k <= 112; k++) begin
            tick(1);
            if (k >= 108) begin
                e_try = 4'd2; e_rst = 1'b1; e_fail = 1'b1;
            end else begin
                e_try = 4'(k / 36);
                e_rst = ((k % 36) < 4) ? 1'b1 : 1'b0;
                e_fail = 1'b0;
            end
            e_icp = (e_try == 4'd0) ? 6'd60 : 6'd63;
            e_lpf = 3'd2 + 3'(e_try);
            chk_all(1000 + k, e_rst, e_icp, e_lpf, 1'b0, e_fail, e_try, 8'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pll_lock_seq.md
# pll_lock_seq

PLL bring-up and lock-supervision sequencer for the Gowin GW5AST PLL wrappers (DDR3 and fabric PLLs). Drives the PLL `reset` input and the dynamic charge-pump/loop-filter controls (`icpsel`, `lpfres`, `lpfcap`), waits for lock with a timeout, and requires the lock to stay stable before it asserts `ready_o`. If lock is not reached, it steps the loop-filter settings and retries. After lock loss it re-locks automatically. Runs on the free-running board reference clock that also feeds the PLL `clkin`.

## Interface
- `RST_CYCLES`, 16: cycles `pll_reset_o` is held high per attempt (≥1).
- `LOCK_TIMEOUT`, 65536: max cycles waiting for lock per attempt (≥2).
- `STABLE_CYCLES`, 1024: consecutive synced-lock cycles required before ready (≥1).
- `MAX_TRIES`, 8: attempts before declaring failure (1..15).
- `ICP_INIT`, 16: initial `icpsel_o`.
- `ICP_STEP`, 4: `icpsel_o` increment per failed attempt.
- `LPFRES_INIT`, 2: initial `lpfres_o`.
- `LPFCAP_VAL`, 0: constant `lpfcap_o`.
- `CNT_W`, 17: shared counter width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES).

Ports:
- `clk` in 1: reference clock.
- `rst_n` in 1: asynchronous active-low reset.
- `restart_i` in 1: single-cycle pulse; restarts the full sequence from try 0.
- `pll_lock_i` in 1: raw PLL `lock`, asynchronous to `clk`.
- `pll_reset_o` out 1: to PLL `reset`.
- `icpsel_o` out 6: to PLL `icpsel`.
- `lpfres_o` out 3: to PLL `lpfres`.
- `lpfcap_o` out 2: to PLL `lpfcap`.
- `ready_o` out 1: PLL locked and stable.
- `fail_o` out 1: all tries exhausted.
- `try_o` out 4: current attempt index.
- `relock_cnt_o` out 8: saturating count of lock losses seen in RUN.

## Operation
- `pll_lock_i` is synchronised through 2 flops to give `lock_s`. All decisions use `lock_s`.
- All outputs are registered. Values while `rst_n`=0:
  - `pll_reset_o`=1
  - `icpsel_o`=ICP_INIT, `lpfres_o`=LPFRES_INIT, `lpfcap_o`=LPFCAP_VAL
  - `ready_o`=0, `fail_o`=0, `try_o`=0, `relock_cnt_o`=0
  - state=PRST, counter=0
- States and transitions:
  - **PRST**: `pll_reset_o`=1. After RST_CYCLES cycles, go to WAIT (`pll_reset_o`←0, counter←0).
  - **WAIT**: if `lock_s`=1, go to STAB (counter←0). Else if counter=LOCK_TIMEOUT-1, handle a failed attempt:
    - If `try_o`=MAX_TRIES-1, go to FAIL.
    - Otherwise: `try_o`+1; `icpsel_o`←min(`icpsel_o`+ICP_STEP, 63); `lpfres_o`+1 mod 8; go to PRST.
  - **STAB**: if `lock_s`=0, go to WAIT (counter←0; the timeout restarts and `try_o` is unchanged). Else if counter=STABLE_CYCLES-1, go to RUN and set `ready_o`←1.
  - **RUN**: if `lock_s`=0, set `ready_o`←0, `relock_cnt_o`+1 (saturates at 255), and go to PRST. Settings and `try_o` are unchanged.
  - **FAIL**: `fail_o`=1 and `pll_reset_o`=1. Holds until `restart_i` or reset.
- `restart_i`=1 in any state, on the next edge:
  - state←PRST, counter←0
  - `try_o`←0, `icpsel_o`←ICP_INIT, `lpfres_o`←LPFRES_INIT
  - `ready_o`←0, `fail_o`←0, `pll_reset_o`←1
  - `relock_cnt_o` is kept.
  - `restart_i` has priority over every other transition in the same cycle.
- `icpsel_o` and `lpfres_o` change only on the edge that enters PRST. They are therefore stable for the whole time the PLL is in reset.

## Timing
- Lock input latency: a raw `pll_lock_i` edge is visible in `lock_s` 2 cycles later.
- After `rst_n` deasserts, `pll_reset_o` stays high for exactly RST_CYCLES cycles.
- `ready_o` rises exactly STABLE_CYCLES cycles after the first edge on which WAIT samples `lock_s`=1, provided lock holds throughout.
- `ready_o` falls on the edge after `lock_s` is sampled 0 in RUN, i.e. 3 cycles after the raw lock drop. `pll_reset_o` rises on the same edge.
- A failed attempt lasts RST_CYCLES + LOCK_TIMEOUT cycles.
- `fail_o` rises on the edge ending the last WAIT. Worst case this is MAX_TRIES·(RST_CYCLES+LOCK_TIMEOUT) cycles after reset release.
- A lock glitch shorter than STABLE_CYCLES during STAB only restarts the stability count. It never reaches `ready_o`.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_TRIES=3, ICP_INIT=60, ICP_STEP=4.

1. Nominal lock: release reset, raise `pll_lock_i` 10 cycles after `pll_reset_o` falls.
   -> `pll_reset_o` high for exactly 4 cycles; `ready_o` rises 2+8 cycles after the lock edge; `try_o`=0; `icpsel_o`=60.
2. Never lock: hold `pll_lock_i`=0.
   -> `try_o` goes 0→1→2; `icpsel_o` goes 60→63→63 (saturates); `lpfres_o` goes 2→3→4; `fail_o`=1 at cycle 108; `pll_reset_o`=1 thereafter.
3. Lock glitch in STAB: lock high for 5 cycles, low for 1 cycle, then high.
   -> `ready_o` stays 0 until 8 synced cycles after the second rise; `try_o` unchanged.
4. Lock loss in RUN: after `ready_o`=1, drop `pll_lock_i`.
   -> 3 cycles later `ready_o`=0, `pll_reset_o`=1, `relock_cnt_o`=1; re-lock reasserts `ready_o` with the same settings.
5. Restart from FAIL with `restart_i` pulsed in the same cycle as a WAIT timeout.
   -> restart wins; `fail_o`=0, `try_o`=0, `icpsel_o`=60, `lpfres_o`=2, `relock_cnt_o` retained.
6. Reset mid-STAB: assert `rst_n`=0.
   -> all outputs take their reset values immediately (asynchronously); the sequence restarts cleanly after release.
